// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests (default: load/store wins).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_RD  = 2'd1;
    localparam logic [1:0] S_MEM_RD = 2'd2;
    localparam logic [1:0] S_MEM_WR = 2'd3;

    logic [1:0]        state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [2:0]        n_bytes, n_bytes_n;
    logic [ADDR_W-1:0] ram_a_n;
    logic [7:0]        ram_dout_n;
    logic              wr_q, wr_n;
    logic [31:0]       if_data_n, mem_rdata_n;
    logic              if_done_n, mem_done_n;
    logic              prev_valid, prev_valid_n;
    logic [1:0]        prev_idx, prev_idx_n;
    logic [31:0]       rd_buf, cap_buf, buf_n;
    logic [2:0]        len_bytes;
    logic              grant_mem, grant_if;

`ifdef MEM_ARB_RR_EN
    logic last_mem, last_mem_n;
`endif

    // Write strobe drops immediately whenever the block is frozen
    assign ram_wr = wr_q & rdy;

    always_comb begin
        case (mem_len)
            2'd0:    len_bytes = 3'd1;
            2'd1:    len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    end

    always_comb begin
`ifdef MEM_ARB_RR_EN
        grant_mem = mem_req && (!if_req || !last_mem);
`else
        grant_mem = mem_req;
`endif
        grant_if = if_req && !grant_mem;
    end

    // ram_din always reflects the address held in the previous cycle, so capture
    // follows that pipeline even while frozen; re-reads of a held address are idempotent.
    always_comb begin
        cap_buf = rd_buf;
        if (prev_valid)
            cap_buf[{prev_idx, 3'b000} +: 8] = ram_din;
        prev_valid_n = ((state == S_IF_RD) || (state == S_MEM_RD)) && (cnt < n_bytes);
        prev_idx_n   = cnt[1:0];
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        n_bytes_n   = n_bytes;
        ram_a_n     = ram_a;
        ram_dout_n  = ram_dout;
        wr_n        = 1'b0;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        if_done_n   = 1'b0;
        mem_done_n  = 1'b0;
        buf_n       = cap_buf;
`ifdef MEM_ARB_RR_EN
        last_mem_n  = last_mem;
`endif
        case (state)
            S_IDLE: begin
                if (!if_done && !mem_done) begin
                    if (grant_mem) begin
                        state_n    = mem_we ? S_MEM_WR : S_MEM_RD;
                        cnt_n      = 3'd0;
                        n_bytes_n  = len_bytes;
                        ram_a_n    = mem_addr;
                        ram_dout_n = mem_wdata[7:0];
                        wr_n       = mem_we;
                        buf_n      = 32'd0;
`ifdef MEM_ARB_RR_EN
                        last_mem_n = 1'b1;
`endif
                    end else if (grant_if) begin
                        state_n    = S_IF_RD;
                        cnt_n      = 3'd0;
                        n_bytes_n  = 3'd4;
                        ram_a_n    = if_addr;
                        buf_n      = 32'd0;
`ifdef MEM_ARB_RR_EN
                        last_mem_n = 1'b0;
`endif
                    end
                end
            end
            S_IF_RD, S_MEM_RD: begin
                if (cnt == n_bytes) begin
                    state_n = S_IDLE;
                    cnt_n   = 3'd0;
                    if (state == S_IF_RD) begin
                        if_data_n = cap_buf;
                        if_done_n = 1'b1;
                    end else begin
                        mem_rdata_n = cap_buf;
                        mem_done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 3'd1;
                    if (cnt < n_bytes - 3'd1)
                        ram_a_n = ram_a + ADDR_W'(1);
                end
            end
            S_MEM_WR: begin
                if (cnt == n_bytes - 3'd1) begin
                    state_n    = S_IDLE;
                    cnt_n      = 3'd0;
                    mem_done_n = 1'b1;
                end else begin
                    cnt_n      = cnt + 3'd1;
                    ram_a_n    = ram_a + ADDR_W'(1);
                    ram_dout_n = mem_wdata[{cnt[1:0] + 2'd1, 3'b000} +: 8];
                    wr_n       = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            n_bytes    <= 3'd0;
            ram_a      <= '0;
            ram_dout   <= 8'd0;
            wr_q       <= 1'b0;
            if_data    <= 32'd0;
            mem_rdata  <= 32'd0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            prev_valid <= 1'b0;
            prev_idx   <= 2'd0;
            rd_buf     <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_mem   <= 1'b0;
`endif
        end else begin
            prev_valid <= prev_valid_n;
            prev_idx   <= prev_idx_n;
            if (rdy) begin
                state     <= state_n;
                cnt       <= cnt_n;
                n_bytes   <= n_bytes_n;
                ram_a     <= ram_a_n;
                ram_dout  <= ram_dout_n;
                wr_q      <= wr_n;
                if_data   <= if_data_n;
                mem_rdata <= mem_rdata_n;
                if_done   <= if_done_n;
                mem_done  <= mem_done_n;
                rd_buf    <= buf_n;
`ifdef MEM_ARB_RR_EN
                last_mem  <= last_mem_n;
`endif
            end else begin
                rd_buf <= cap_buf;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, RAM model, completion scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, if_done, mem_req, mem_we, mem_done, ram_wr;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
    logic [1:0]  mem_len;
    logic [7:0]  ram_dout, ram_din;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:16383];
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[13:0]] <= ram_dout;
        ram_din <= ram[ram_a[13:0]];
    end

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Completion monitor: every done pulse pops the expected requester and data
    always @(negedge clk) begin
        if (if_done || mem_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("done_source", {31'd0, mem_done}, {31'd0, e.is_mem});
                if (mem_done) chk("mem_rdata", mem_rdata, e.data);
                else          chk("if_data", if_data, e.data);
            end
        end
    end

    task automatic run_txn(input logic is_mem, input logic we, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wdata,
                           input logic [31:0] exp, input int stall_at, input int stall_len);
        int n, lat, k, eff;
        logic seen;
        logic [31:0] wd;
        n   = !is_mem ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        lat = (is_mem && we ? n + 1 : n + 2) + stall_len;
        if (is_mem && we) sb.push_back('{1'b1, model_rdata});
        else begin
            sb.push_back('{is_mem, exp});
            if (is_mem) model_rdata = exp;
        end
        wd = wdata;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (stall_len == 0 || k <= stall_at) eff = k;
            else if (k <= stall_at + stall_len) eff = stall_at;
            else eff = k - stall_len;
            if (eff >= 1 && eff <= n) begin
                chk("ram_a", ram_a, addr + 32'(eff - 1));
                chk("ram_wr_active", {31'd0, ram_wr}, {31'd0, is_mem && we && rdy});
                if (is_mem && we) chk("ram_dout", {24'd0, ram_dout}, {24'd0, wd[8*(eff-1) +: 8]});
            end else begin
                chk("ram_wr_idle", {31'd0, ram_wr}, 32'd0);
            end
            if (stall_len > 0 && k == stall_at) rdy = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) rdy = 1'b1;
            if (if_done || mem_done) begin
                seen = 1'b1;
                chk("latency", 32'(k), 32'(lat));
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        if (!seen) chk("done_timeout", 32'(k), 32'(lat));
    endtask

    task automatic prio_round(input logic exp_mem);
        int k;
        logic seen;
        if (exp_mem) begin
            sb.push_back('{1'b1, 32'hDEADBEEF});
            model_rdata = 32'hDEADBEEF;
        end else begin
            sb.push_back('{1'b0, 32'h00100513});
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_len = 2'd2;
        if_req  = 1'b1; if_addr = 32'h100;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (if_done || mem_done) begin
                seen = 1'b1;
                chk("prio_winner", {31'd0, mem_done}, {31'd0, exp_mem});
                chk("prio_latency", 32'(k), 32'd6);
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        if (!seen) chk("prio_timeout", 32'(k), 32'd6);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ram_a"}, ram_a, 32'd0);
        chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
        chk({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_dones"}, {30'd0, if_done, mem_done}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_rdata = 32'd0;
        check_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         32'h0010_0513};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_2000, 2'd2, 32'hDEADBEEF,  32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_2002, 2'd1, 32'h0,         32'h0000_DEAD};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_2001, 2'd0, 32'h0,         32'h0000_00BE};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_2000, 2'd3, 32'h0,         32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_2010, 2'd0, 32'h11223344,  32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_2010, 2'd2, 32'h0,         32'h0000_0044};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_2020, 2'd1, 32'h9999A55A,  32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_2020, 2'd2, 32'h0,         32'h0000_A55A};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 2'd2, 32'h01020304,  32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0,         32'h0102_0304};

        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        ram[14'h100] = 8'h13; ram[14'h101] = 8'h05; ram[14'h102] = 8'h10; ram[14'h103] = 8'h00;

        rst = 1'b0; rdy = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 2'd0; mem_wdata = 32'd0;
        model_rdata = 32'd0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].len,
                    vecs[i].wdata, vecs[i].exp, 0, 0);
            @(negedge clk);
        end

        // Freeze for three cycles while byte 2 of a fetch is in flight
        run_txn(1'b0, 1'b0, 32'h100, 2'd2, 32'd0, 32'h0010_0513, 3, 3);
        @(negedge clk);

        // Reset lands while byte 1 of a store is on the RAM port
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2040; mem_len = 2'd2; mem_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_ram_a", ram_a, 32'h2041);
        rst = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        model_rdata = 32'd0;
        check_zero_outputs("abort");
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(1'b0, 1'b0, 32'h100, 2'd2, 32'd0, 32'h0010_0513, 0, 0);
        @(negedge clk);

        // Simultaneous requests from a fresh reset, twice
        do_reset();
`ifdef MEM_ARB_RR_EN
        prio_round(1'b1);
        prio_round(1'b0);
`else
        prio_round(1'b1);
        prio_round(1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of all address ports.
REQ-002 Clock and reset are as follows.
  - clk  in  1  single clock.
  - rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 rdy  in  1  global ready; 0 freezes the block.
REQ-004 Fetch ports are as follows.
  - if_req  in  1  fetch request.
  - if_addr  in  ADDR_W  fetch address.
  - if_data  out  32  fetched word.
  - if_done  out  1  one-cycle fetch completion pulse.
REQ-005 Load/store ports are as follows.
  - mem_req  in  1  load/store request.
  - mem_we  in  1  1 = store.
  - mem_addr  in  ADDR_W  byte address.
  - mem_len  in  2  access size (0 = 1B, 1 = 2B, 2 = 4B, 3 = 4B).
  - mem_wdata  in  32  store data.
  - mem_rdata  out  32  load data, zero-extended.
  - mem_done  out  1  one-cycle completion pulse.
REQ-006 RAM ports are as follows.
  - ram_a  out  ADDR_W  byte address.
  - ram_dout  out  8  write byte.
  - ram_wr  out  1  write strobe.
  - ram_din  in  8  read byte; valid one cycle after ram_a with ram_wr = 0.

Function
REQ-007 The block SHALL share the single byte-wide RAM port between fetch and load/store, serialising each access into N byte cycles, where N = 1, 2 or 4 (fetch is always N = 4).
REQ-008 The FSM SHALL have states IDLE, IF_RD, MEM_RD, MEM_WR and a 3-bit byte counter.
REQ-009 Grant SHALL be sampled only in IDLE; a request sampled at cycle T SHALL start byte 0 at T+1.
REQ-010 With both requests high in IDLE, mem_req SHALL win (fixed priority) unless MEM_ARB_RR_EN is defined.
REQ-011 Reads: at cycles T+1..T+N, ram_a SHALL equal addr+i (i = 0..N-1) with ram_wr = 0.
  - ram_din SHALL be captured at T+2..T+N+1.
  - Data SHALL be assembled little-endian (byte i into bits 8i+7:8i).
REQ-012 Read done (if_done or mem_done) SHALL pulse at T+N+2 with data valid in the same cycle; the FSM SHALL be in IDLE in that cycle.
REQ-013 Stores: at cycles T+1..T+N, ram_a SHALL equal addr+i, ram_wr = 1, and ram_dout SHALL equal wdata byte i; mem_done SHALL pulse at T+N+1.
REQ-014 Requesters SHALL hold req and operands stable until done; the arbiter SHALL NOT grant in the cycle done is high (earliest new grant is done+1).
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-016 Outside an active store cycle, ram_wr SHALL be 0.
REQ-017 if_data and mem_rdata SHALL hold their last value between done pulses.
REQ-018 When rdy = 0, all state, counters, outputs and captured data SHALL hold, except that ram_wr SHALL be forced to 0.
  - An in-flight read byte SHALL be re-issued on the same ram_a when rdy returns.

Reset
REQ-019 With rst = 0 at a clock edge, the FSM SHALL go to IDLE with counter = 0.
  - ram_a, ram_dout, if_data and mem_rdata SHALL be 0.
  - ram_wr, if_done and mem_done SHALL be 0.
  - The round-robin pointer SHALL point at the fetch requester.
REQ-020 Reset SHALL take priority over rdy and abort any in-flight access; partial stores are not rolled back.

Configuration
REQ-021 MEM_ARB_RR_EN is the only configuration macro.
  - Defined: on simultaneous requests in IDLE, the requester not served last wins; the pointer updates on each grant.
  - Undefined: fixed mem_req priority; no pointer register is built.

Verification
REQ-022 Fetch only, if_addr = 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 at T+1..T+4; if_data = 0x00100513 with if_done at T+6.
REQ-023 Store word, mem_addr = 0x2000, mem_wdata = 0xDEADBEEF -> ram_wr = 1 with bytes EF,BE,AD,DE at 0x2000..0x2003; mem_done at T+5.
REQ-024 Load half, mem_addr = 0x2002 after REQ-023 -> mem_rdata = 0x0000DEAD; mem_done at T+4.
REQ-025 if_req and mem_req both high from IDLE, repeated twice -> without the macro, mem served both times; with the macro, mem then fetch.
REQ-026 rdy low for 3 cycles during byte 2 of a fetch -> done delayed by exactly 3 cycles with correct data and ram_wr = 0 throughout.
REQ-027 rst low during byte 1 of a store -> next cycle IDLE with all outputs 0 and no mem_done; a following fetch completes normally.
